// File: rtl/demux_stream_n.sv
// demux_stream_n
// Registered 1-to-N stream demultiplexer with a valid/ready handshake on
// the input and on each output channel. An accepted word goes either to the
// channel selected by key or, in broadcast mode, to every channel. Each
// channel holds its word in a one-entry register until its consumer takes it.
// A word whose key names no channel is accepted and dropped, and
// drop_count records it, saturating at 255.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   in_data, key         input word and destination channel index
//   broadcast            send the word to all channels, ignoring key
//   in_valid, in_ready   input handshake
//   out_data             channel i at [i*WIDTH +: WIDTH]
//   out_valid, out_ready per-channel output handshake
//   drop_count           saturating count of words with an out-of-range key
module demux_stream_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int KEY_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [KEY_W-1:0]          key,
  input  logic                      broadcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [7:0]                drop_count
);

  localparam logic [31:0] CH_U = 32'(CHANNELS);

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] sel;
  logic [CHANNELS-1:0] load;
  logic                key_ok;
  logic                in_hs;

  assign free   = ~out_valid | out_ready;
  assign key_ok = 32'(key) < CH_U;

  // One-hot decode of key; all zero when key names no channel, so an
  // out-of-range key never indexes past the channel vector.
  always_comb begin
    sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel[i] = key_ok && (key == KEY_W'(i));
    end
  end

  // An invalid key is always accepted so the stream never stalls on garbage.
  always_comb begin
    if (broadcast)   in_ready = &free;
    else if (key_ok) in_ready = |(sel & free);
    else             in_ready = 1'b1;
  end

  assign in_hs = in_valid & in_ready;
  assign load  = {CHANNELS{in_hs}} & ({CHANNELS{broadcast}} | sel);

  // A reload on the same edge as a drain keeps out_valid high, giving
  // full throughput without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (load[i]) begin
          out_data[i*WIDTH +: WIDTH] <= in_data;
          out_valid[i]               <= 1'b1;
        end else if (out_ready[i]) begin
          out_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= 8'd0;
    end else if (in_hs && !broadcast && !key_ok && drop_count != 8'hFF) begin
      drop_count <= drop_count + 8'd1;
    end
  end

endmodule
